regfile_wb_ctrl: RTL

- Write-back controller for the 32x32 register file in the single-cycle core. It owns the register file's single write port.
- Arbitrates between two write-back requesters, EXU (req0, ALU results) and LSU (req1, load data), using round-robin on a valid/ready handshake.
- Keeps a busy scoreboard per architectural register so decode can detect RAW/WAW hazards before issue.
- Drives the register file's write register, data and enable directly from registered outputs.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_wb_ctrl_rr_arb2.sv | 42 ++++
 rtl/regfile_wb_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back slice.
package regfile_pkg;

  localparam int REG_WIDTH   = 32;
  localparam int REG_NUM     = 32;
  localparam int REG_KEY_LEN = 5;

  // Identifies which write-back requester a grant or pointer refers to.
  typedef enum logic {
    REQ_EXU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

// File: rtl/regfile_wb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins
// the next tie, and moves to the other requester after each transfer.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic grant0,
  output logic grant1
);

  req_id_e ptr;

  // A lone requester always wins; on a tie the pointer decides.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0 && req1) begin
      if (ptr == REQ_EXU) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else begin
      grant0 = req0;
      grant1 = req1;
    end
  end

  // After a transfer, favour whichever requester did not just win.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= REQ_EXU;
    end else if (update) begin
      ptr <= grant0 ? REQ_LSU : REQ_EXU;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: owns the register file write port, arbitrates
// EXU/LSU results and tracks pending writes for decode hazard checks.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int WIDTH   = REG_WIDTH,
  parameter int REGNUM  = REG_NUM,
  parameter int KEY_LEN = REG_KEY_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [KEY_LEN-1:0] req0_rd,
  input  logic [WIDTH-1:0]   req0_data,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [KEY_LEN-1:0] req1_rd,
  input  logic [WIDTH-1:0]   req1_data,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [KEY_LEN-1:0] issue_rd,
  input  logic [KEY_LEN-1:0] rs1_idx,
  input  logic [KEY_LEN-1:0] rs2_idx,
  output logic               rs1_busy,
  output logic               rs2_busy,
  output logic [KEY_LEN-1:0] wb_reg,
  output logic [WIDTH-1:0]   wb_data,
  output logic               wb_en
);

  logic               grant0;
  logic               grant1;
  logic               xfer;
  logic [KEY_LEN-1:0] sel_rd;
  logic [WIDTH-1:0]   sel_data;
  logic               issue_fire;
  logic [REGNUM-1:0]  busy;
  logic [REGNUM-1:0]  busy_next;

  // Requests are masked during reset so no ready is raised and nothing is taken.
  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0_valid && !rst),
    .req1   (req1_valid && !rst),
    .update (xfer),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  // Handshake outputs and the payload of whichever requester was granted.
  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    xfer       = grant0 || grant1;
    sel_rd     = grant1 ? req1_rd   : req0_rd;
    sel_data   = grant1 ? req1_data : req0_data;
  end

  // Write-back register: a single-cycle enable pulse per non-x0 transfer;
  // register and data hold their last written values between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en   <= 1'b0;
      wb_reg  <= '0;
      wb_data <= '0;
    end else begin
      wb_en <= xfer && (sel_rd != '0);
      if (xfer && (sel_rd != '0)) begin
        wb_reg  <= sel_rd;
        wb_data <= sel_data;
      end
    end
  end

  // Issue is accepted unless its destination still has a write pending.
  always_comb begin
    issue_ready = !rst && ((issue_rd == '0) || !busy[issue_rd]);
    issue_fire  = issue_valid && issue_ready;
    rs1_busy    = busy[rs1_idx];
    rs2_busy    = busy[rs2_idx];
  end

  // Clear on the completing write-back first so a same-edge issue wins.
  always_comb begin
    busy_next = busy;
    if (wb_en) begin
      busy_next[wb_reg] = 1'b0;
    end
    if (issue_fire && (issue_rd != '0)) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule
